// File: rtl/stream_checker_sink.sv
// ============================================================================
// Module   : stream_checker_sink
// Purpose  : Terminal valid/ready sink that applies a selectable backpressure
//            pattern and checks beats against an incrementing sequence.
// Options  : STREAM_SINK_RESYNC_EN - resynchronise the reference on mismatch
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_checker_sink #(
    parameter int         D_WIDTH   = 6,
    parameter int         CNT_WIDTH = 16,
    parameter int         NUM_BEATS = 64,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [D_WIDTH-1:0]   up_data,
    input  logic                 up_valid,
    output logic                 up_ready,
    input  logic                 enable,
    input  logic [1:0]           bp_mode,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] beat_count,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic                 err_flag,
    output logic [D_WIDTH-1:0]   first_err_data
);

    localparam logic [CNT_WIDTH-1:0] c_last_beat = CNT_WIDTH'(NUM_BEATS - 1);
    localparam logic [CNT_WIDTH-1:0] c_err_max   = {CNT_WIDTH{1'b1}};
    localparam logic [7:0]           c_lfsr_taps = 8'hB8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_ready;
    logic                 w_ready_nxt;
    logic                 r_toggle;
    logic                 w_toggle_nxt;
    logic [7:0]           r_lfsr;
    logic [7:0]           w_lfsr_nxt;
    logic [CNT_WIDTH-1:0] r_beat;
    logic [CNT_WIDTH-1:0] r_err;
    logic                 r_err_flag;
    logic [D_WIDTH-1:0]   r_first_err;
    logic [D_WIDTH-1:0]   r_expected;
    logic                 w_hs;
    logic                 w_start;

    // r_ready is only ever set while heading into RUN, so hs implies RUN.
    assign w_hs    = up_valid & r_ready;
    assign w_start = (r_state == S_IDLE) && enable;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (enable) w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_hs && (r_beat == c_last_beat)) w_state_nxt = S_DONE;
                else if (!enable)                    w_state_nxt = S_IDLE;
            end
            S_DONE: if (!enable) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Pattern generators look one step ahead so the registered ready
    // presents the first pattern value in the first RUN cycle.
    always_comb begin
        w_toggle_nxt = r_toggle;
        w_lfsr_nxt   = r_lfsr;
        if (w_start) begin
            w_toggle_nxt = 1'b0;
            w_lfsr_nxt   = LFSR_SEED;
        end else if (r_state == S_RUN) begin
            w_toggle_nxt = ~r_toggle;
            w_lfsr_nxt   = {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? c_lfsr_taps : 8'h00);
        end

        w_ready_nxt = 1'b0;
        if (w_state_nxt == S_RUN) begin
            case (bp_mode)
                2'b00:   w_ready_nxt = 1'b1;
                2'b01:   w_ready_nxt = w_toggle_nxt;
                2'b10:   w_ready_nxt = w_lfsr_nxt[0];
                default: w_ready_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b0;
            r_toggle    <= 1'b0;
            r_lfsr      <= LFSR_SEED;
            r_beat      <= '0;
            r_err       <= '0;
            r_err_flag  <= 1'b0;
            r_first_err <= '0;
            r_expected  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ready  <= w_ready_nxt;
            r_toggle <= w_toggle_nxt;
            r_lfsr   <= w_lfsr_nxt;
            if (w_start) begin
                r_beat     <= '0;
                r_err      <= '0;
                r_err_flag <= 1'b0;
                r_expected <= '0;
            end else if (w_hs) begin
                r_beat <= r_beat + 1'b1;
                if (up_data != r_expected) begin
                    if (r_err != c_err_max) r_err <= r_err + 1'b1;
                    r_err_flag <= 1'b1;
                    if (!r_err_flag) r_first_err <= up_data;
`ifdef STREAM_SINK_RESYNC_EN
                    r_expected <= up_data + 1'b1;
`else
                    r_expected <= r_expected + 1'b1;
`endif
                end else begin
                    r_expected <= r_expected + 1'b1;
                end
            end
        end
    end

    assign up_ready       = r_ready;
    assign busy           = (r_state == S_RUN);
    assign done           = (r_state == S_DONE);
    assign beat_count     = r_beat;
    assign err_count      = r_err;
    assign err_flag       = r_err_flag;
    assign first_err_data = r_first_err;

endmodule

`default_nettype wire

// File: tb/tb_stream_checker_sink.sv
// ============================================================================
// Module   : tb_stream_checker_sink
// Purpose  : Directed self-checking bench for stream_checker_sink.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_checker_sink;

    logic        clk;
    logic        rst;
    logic [5:0]  up_data;
    logic        up_valid;
    logic [1:0]  bp_mode;
    logic        en_a, en_b, en_c;

    logic        rdy_a, busy_a, done_a, flag_a;
    logic [15:0] beat_a, err_a;
    logic [5:0]  fed_a;
    logic        rdy_b, busy_b, done_b, flag_b;
    logic [15:0] beat_b, err_b;
    logic [5:0]  fed_b;
    logic        rdy_c, busy_c, done_c, flag_c;
    logic [15:0] beat_c, err_c;
    logic [5:0]  fed_c;

    logic [5:0]  seq [0:127];
    int          tests_run;
    int          tests_failed;

    stream_checker_sink u_dut_a (
        .clk(clk), .rst(rst), .up_data(up_data), .up_valid(up_valid), .up_ready(rdy_a),
        .enable(en_a), .bp_mode(bp_mode), .busy(busy_a), .done(done_a),
        .beat_count(beat_a), .err_count(err_a), .err_flag(flag_a), .first_err_data(fed_a)
    );

    stream_checker_sink #(.NUM_BEATS(5)) u_dut_b (
        .clk(clk), .rst(rst), .up_data(up_data), .up_valid(up_valid), .up_ready(rdy_b),
        .enable(en_b), .bp_mode(bp_mode), .busy(busy_b), .done(done_b),
        .beat_count(beat_b), .err_count(err_b), .err_flag(flag_b), .first_err_data(fed_b)
    );

    stream_checker_sink #(.NUM_BEATS(70)) u_dut_c (
        .clk(clk), .rst(rst), .up_data(up_data), .up_valid(up_valid), .up_ready(rdy_c),
        .enable(en_c), .bp_mode(bp_mode), .busy(busy_c), .done(done_c),
        .beat_count(beat_c), .err_count(err_c), .err_flag(flag_c), .first_err_data(fed_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    // Called at a negedge; the DUT is in its first RUN cycle at the next negedge.
    task automatic start_run(input int which, input logic [1:0] mode);
        bp_mode = mode;
        if (which == 0) en_a = 1'b1;
        else if (which == 1) en_b = 1'b1;
        else en_c = 1'b1;
        @(posedge clk);
    endtask

    task automatic stop_run();
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Offers seq[0..len-1]; cycles counts clocks from the first RUN cycle to the last beat.
    task automatic send_seq(input int which, input int len, input int max_cycles,
                            output int cycles, output logic [7:0] pat);
        int   idx;
        logic r;
        idx = 0; cycles = 0; pat = '0;
        while (idx < len && cycles < max_cycles) begin
            @(negedge clk);
            up_data  = seq[idx];
            up_valid = 1'b1;
            r = (which == 0) ? rdy_a : (which == 1) ? rdy_b : rdy_c;
            if (cycles < 8) pat[cycles] = r;
            @(posedge clk);
            cycles++;
            if (r) idx++;
        end
        @(negedge clk);
        up_valid = 1'b0;
        tests_run++;
        if (idx !== len) begin
            tests_failed++;
            $display("FAIL send_timeout: accepted %0d beats, required %0d", idx, len);
        end
    endtask

    task automatic fill_ramp(input int len);
        for (int i = 0; i < len; i++) seq[i] = 6'(i % 64);
    endtask

    task automatic test_reset();
        rst = 1'b0; up_data = '0; up_valid = 1'b0; bp_mode = 2'b00;
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++; if (rdy_a !== 1'b0)  begin tests_failed++; $display("FAIL reset_ready: got %0b want 0", rdy_a); end
        tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b want 0", busy_a); end
        tests_run++; if (done_a !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %0b want 0", done_a); end
        tests_run++; if (beat_a !== 16'd0 || err_a !== 16'd0) begin tests_failed++; $display("FAIL reset_counts: got beat %0d err %0d want 0 0", beat_a, err_a); end
        tests_run++; if (flag_a !== 1'b0 || fed_a !== 6'd0) begin tests_failed++; $display("FAIL reset_err: got flag %0b fed %0d want 0 0", flag_a, fed_a); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_always_ready();
        int cyc; logic [7:0] pat;
        fill_ramp(64);
        start_run(0, 2'b00);
        send_seq(0, 64, 200, cyc, pat);
        tests_run++; if (cyc !== 64)        begin tests_failed++; $display("FAIL t1_cycles: got %0d want 64", cyc); end
        tests_run++; if (done_a !== 1'b1)   begin tests_failed++; $display("FAIL t1_done: got %0b want 1", done_a); end
        tests_run++; if (beat_a !== 16'd64) begin tests_failed++; $display("FAIL t1_beat: got %0d want 64", beat_a); end
        tests_run++; if (err_a !== 16'd0 || flag_a !== 1'b0) begin tests_failed++; $display("FAIL t1_err: got err %0d flag %0b want 0 0", err_a, flag_a); end
        tests_run++; if (rdy_a !== 1'b0 || busy_a !== 1'b0) begin tests_failed++; $display("FAIL t1_ready_done: got ready %0b busy %0b want 0 0", rdy_a, busy_a); end
        stop_run();
        tests_run++; if (done_a !== 1'b0)   begin tests_failed++; $display("FAIL t1_idle: got done %0b want 0", done_a); end
    endtask

    task automatic test_alternate();
        int cyc; logic [7:0] pat;
        fill_ramp(64);
        start_run(0, 2'b01);
        send_seq(0, 64, 300, cyc, pat);
        tests_run++; if (pat[3:0] !== 4'b1010) begin tests_failed++; $display("FAIL t2_pattern: got %b want 1010", pat[3:0]); end
        tests_run++; if (cyc !== 128)       begin tests_failed++; $display("FAIL t2_cycles: got %0d want 128", cyc); end
        tests_run++; if (beat_a !== 16'd64 || err_a !== 16'd0) begin tests_failed++; $display("FAIL t2_result: got beat %0d err %0d want 64 0", beat_a, err_a); end
        stop_run();
    endtask

    task automatic test_lfsr();
        int cyc; logic [7:0] pat;
        fill_ramp(64);
        start_run(0, 2'b10);
        send_seq(0, 64, 400, cyc, pat);
        // Seed A5 stepping A5,EA,75,82,41,98 gives ready bits 1,0,1,0,1,0.
        tests_run++; if (pat[5:0] !== 6'b010101) begin tests_failed++; $display("FAIL lfsr_pattern: got %b want 010101", pat[5:0]); end
        tests_run++; if (done_a !== 1'b1 || err_a !== 16'd0) begin tests_failed++; $display("FAIL lfsr_result: got done %0b err %0d want 1 0", done_a, err_a); end
        stop_run();
    endtask

    task automatic test_drop();
        int cyc; logic [7:0] pat;
        int exp_err;
        seq[0] = 6'd0; seq[1] = 6'd1; seq[2] = 6'd2; seq[3] = 6'd4; seq[4] = 6'd5;
`ifdef STREAM_SINK_RESYNC_EN
        exp_err = 1;
`else
        exp_err = 2;
`endif
        start_run(1, 2'b00);
        send_seq(1, 5, 50, cyc, pat);
        tests_run++; if (done_b !== 1'b1 || beat_b !== 16'd5) begin tests_failed++; $display("FAIL t3_done: got done %0b beat %0d want 1 5", done_b, beat_b); end
        tests_run++; if (err_b !== 16'(exp_err)) begin tests_failed++; $display("FAIL t3_err: got %0d want %0d", err_b, exp_err); end
        tests_run++; if (flag_b !== 1'b1 || fed_b !== 6'd4) begin tests_failed++; $display("FAIL t3_first: got flag %0b fed %0d want 1 4", flag_b, fed_b); end
        stop_run();
    endtask

    task automatic test_wrap();
        int cyc; logic [7:0] pat;
        fill_ramp(70);
        start_run(2, 2'b00);
        send_seq(2, 70, 200, cyc, pat);
        tests_run++; if (done_c !== 1'b1 || beat_c !== 16'd70) begin tests_failed++; $display("FAIL t4_done: got done %0b beat %0d want 1 70", done_c, beat_c); end
        tests_run++; if (err_c !== 16'd0 || flag_c !== 1'b0) begin tests_failed++; $display("FAIL t4_err: got err %0d flag %0b want 0 0", err_c, flag_c); end
        stop_run();
    endtask

    task automatic test_never_ready();
        int cyc; logic [7:0] pat;
        logic saw_ready;
        saw_ready = 1'b0;
        start_run(0, 2'b11);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            up_valid = 1'b1; up_data = 6'd0;
            if (rdy_a) saw_ready = 1'b1;
        end
        tests_run++; if (saw_ready !== 1'b0) begin tests_failed++; $display("FAIL t5_ready: got ready seen %0b want 0", saw_ready); end
        tests_run++; if (beat_a !== 16'd0 || busy_a !== 1'b1) begin tests_failed++; $display("FAIL t5_stall: got beat %0d busy %0b want 0 1", beat_a, busy_a); end
        bp_mode = 2'b00;
        fill_ramp(64);
        send_seq(0, 64, 200, cyc, pat);
        tests_run++; if (done_a !== 1'b1 || beat_a !== 16'd64 || err_a !== 16'd0) begin tests_failed++; $display("FAIL t5_result: got done %0b beat %0d err %0d want 1 64 0", done_a, beat_a, err_a); end
        stop_run();
    endtask

    task automatic test_abort_and_reset();
        int cyc; logic [7:0] pat;
        fill_ramp(10);
        start_run(0, 2'b00);
        send_seq(0, 10, 50, cyc, pat);
        en_a = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tests_run++; if (rdy_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin tests_failed++; $display("FAIL t6_abort: got ready %0b busy %0b done %0b want 0 0 0", rdy_a, busy_a, done_a); end
        tests_run++; if (beat_a !== 16'd10) begin tests_failed++; $display("FAIL t6_hold: got beat %0d want 10", beat_a); end

        seq[0] = 6'd0; seq[1] = 6'd1; seq[2] = 6'd2; seq[3] = 6'd9; seq[4] = 6'd4;
        start_run(0, 2'b00);
        send_seq(0, 5, 50, cyc, pat);
        tests_run++; if (flag_a !== 1'b1 || fed_a !== 6'd9 || rdy_a !== 1'b1) begin tests_failed++; $display("FAIL t6_prereset: got flag %0b fed %0d ready %0b want 1 9 1", flag_a, fed_a, rdy_a); end
        #2 rst = 1'b0;
        #1;
        tests_run++; if (rdy_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin tests_failed++; $display("FAIL t6_rst_ctrl: got ready %0b busy %0b done %0b want 0 0 0", rdy_a, busy_a, done_a); end
        tests_run++; if (beat_a !== 16'd0 || err_a !== 16'd0 || flag_a !== 1'b0 || fed_a !== 6'd0) begin tests_failed++; $display("FAIL t6_rst_stat: got beat %0d err %0d flag %0b fed %0d want 0 0 0 0", beat_a, err_a, flag_a, fed_a); end
        en_a = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_always_ready();
        test_alternate();
        test_lfsr();
        test_drop();
        test_wrap();
        test_never_ready();
        test_abort_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
